// File: rtl/vgaconsole_fetch_arbiter_if.sv
// Character-buffer port bundle: CPU write handshake plus the single shared buffer port.
// The slave view belongs to the arbiter; the master view belongs to the CPU/buffer side.
interface vgaconsole_fetch_arbiter_if;
  logic       cpu_wr_req;
  logic [6:0] cpu_wr_addr;
  logic [7:0] cpu_wr_data;
  logic       cpu_wr_ack;
  logic [6:0] buf_addr;
  logic       buf_we;
  logic [7:0] buf_wdata;
  logic [7:0] buf_rdata;

  modport slave (
    input  cpu_wr_req, cpu_wr_addr, cpu_wr_data, buf_rdata,
    output cpu_wr_ack, buf_addr, buf_we, buf_wdata
  );

  modport master (
    output cpu_wr_req, cpu_wr_addr, cpu_wr_data, buf_rdata,
    input  cpu_wr_ack, buf_addr, buf_we, buf_wdata
  );
endinterface

// File: rtl/vgaconsole_fetch_arbiter.sv
// VGA console scan sequencer: sync timing, one character fetch per cell, display-first port arbiter.
// Optional blinking cursor output when VGACON_CURSOR_EN is defined.
module vgaconsole_fetch_arbiter #(
  parameter int H_ACTIVE    = 1024,
  parameter int H_FP        = 24,
  parameter int H_SYNC      = 136,
  parameter int H_BP        = 160,
  parameter int V_ACTIVE    = 768,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 6,
  parameter int V_BP        = 29,
  parameter int COLS        = 16,
  parameter int ROWS        = 6,
  parameter int CELL_W_LOG2 = 6,
  parameter int CELL_H_LOG2 = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  vgaconsole_fetch_arbiter_if.slave   bus,
  output logic [7:0]                  char_out,
  output logic                        char_valid,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        blank,
  output logic                        frame_start
`ifdef VGACON_CURSOR_EN
  ,
  input  logic [6:0]                  cursor_addr,
  output logic                        cursor_on
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = CELL_W_LOG2;
  localparam int NCELLS  = COLS * ROWS;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_PRE    = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SLOTLM = HW'(H_ACTIVE - 2);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] SLOT_PH  = CW'((1 << CW) - 2);
  localparam logic [7:0]    NCELLS_8 = 8'(NCELLS);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          blank_q, blank_d;
  logic [7:0]    char_out_q, char_out_d;
  logic          vld_p1_q, vld_p1_d;
  logic          ack_q, ack_d;
  logic [6:0]    buf_addr_q, buf_addr_d;

  logic          fetch_p0;
  logic [6:0]    fetch_addr_p0;
  logic [HW-1:0] tgt_h;
  logic [VW-1:0] tgt_v;
  logic          grant;

  always_comb begin
    hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST)
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);

    // Sync/blank are registered from the current counters, so they lag hcnt by one clock.
    hsync_d = !(hcnt_q >= HS_BEG && hcnt_q < HS_END);
    vsync_d = !(vcnt_q >= VS_BEG && vcnt_q < VS_END);
    blank_d = !(hcnt_q < H_ACT && vcnt_q < V_ACT);

    // Fetch slot: two clocks before a visible cell; cell 0 is fetched from the end of the prior line.
    fetch_p0 = 1'b0;
    tgt_h    = hcnt_q + HW'(2);
    tgt_v    = vcnt_q;
    if (hcnt_q == H_PRE) begin
      tgt_h    = '0;
      tgt_v    = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      fetch_p0 = (tgt_v < V_ACT);
    end else if (hcnt_q[CW-1:0] == SLOT_PH && hcnt_q < H_SLOTLM && vcnt_q < V_ACT) begin
      fetch_p0 = 1'b1;
    end
    fetch_addr_p0 = 7'((int'(tgt_v) >> CELL_H_LOG2) * COLS + (int'(tgt_h) >> CELL_W_LOG2));

    // The display owns slot cycles; the previous-cycle ack forces an idle gap between grants.
    grant          = rst_n && bus.cpu_wr_req && !fetch_p0 && !ack_q;
    bus.cpu_wr_ack = grant;
    bus.buf_we     = grant && ({1'b0, bus.cpu_wr_addr} < NCELLS_8);
    bus.buf_wdata  = bus.cpu_wr_data;

    buf_addr_d = buf_addr_q;
    if (fetch_p0)
      buf_addr_d = fetch_addr_p0;
    else if (grant)
      buf_addr_d = bus.cpu_wr_addr;
    bus.buf_addr = buf_addr_d;

    ack_d      = grant;
    vld_p1_d   = fetch_p0;
    char_out_d = vld_p1_q ? bus.buf_rdata : char_out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      blank_q    <= 1'b1;
      char_out_q <= '0;
      vld_p1_q   <= 1'b0;
      ack_q      <= 1'b0;
      buf_addr_q <= '0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      blank_q    <= blank_d;
      char_out_q <= char_out_d;
      vld_p1_q   <= vld_p1_d;
      ack_q      <= ack_d;
      buf_addr_q <= buf_addr_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign char_valid  = !blank_q;
  assign char_out    = char_out_q;
  assign frame_start = rst_n && (hcnt_q == '0) && (vcnt_q == '0);

`ifdef VGACON_CURSOR_EN
  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic [6:0] addr_p1_q;
  logic [6:0] cell_q, cell_d;
  logic       cursor_on_q, cursor_on_d;

  // Cell index travels with the fetched character so the cursor lines up with char_out.
  always_comb begin
    frame_cnt_d = frame_start ? frame_cnt_q + 6'd1 : frame_cnt_q;
    cell_d      = vld_p1_q ? addr_p1_q : cell_q;
    cursor_on_d = !blank_d && (cell_d == cursor_addr) && frame_cnt_q[5];
  end

  always_ff @(posedge clk) begin
    addr_p1_q <= fetch_addr_p0;
    cell_q    <= cell_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      cursor_on_q <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      cursor_on_q <= cursor_on_d;
    end
  end

  assign cursor_on = cursor_on_q;
`endif

endmodule

// File: tb/tb_vgaconsole_fetch_arbiter.sv
// Randomized bench for the VGA console fetch arbiter, run with a shrunken raster geometry
// and checked every cycle against a cycle-indexed behavioural model.
module tb_vgaconsole_fetch_arbiter;
  localparam int HA = 32, HFP = 2, HS = 4, HBP = 6;
  localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
  localparam int COLS = 4, ROWS = 3, CWL = 3, CHL = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int NC = COLS * ROWS;
  localparam int CW = 1 << CWL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_out;
  logic       char_valid, hsync, vsync, blank, frame_start;
`ifdef VGACON_CURSOR_EN
  logic [6:0] cursor_addr = 7'd5;
  logic       cursor_on;
`endif

  vgaconsole_fetch_arbiter_if bus();

  vgaconsole_fetch_arbiter #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .COLS(COLS), .ROWS(ROWS), .CELL_W_LOG2(CWL), .CELL_H_LOG2(CHL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .char_out(char_out), .char_valid(char_valid), .hsync(hsync), .vsync(vsync),
    .blank(blank), .frame_start(frame_start)
`ifdef VGACON_CURSOR_EN
    , .cursor_addr(cursor_addr), .cursor_on(cursor_on)
`endif
  );

  always #5 clk = ~clk;

  // Character buffer: synchronous read-old RAM, preloaded with buf[i] = i.
  logic [7:0] ram [128];
  logic       ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 128; i++) ram[i] <= 8'(i);
      ram_init <= 1'b1;
    end else if (bus.buf_we) begin
      ram[bus.buf_addr] <= bus.buf_wdata;
    end
    bus.buf_rdata <= ram[bus.buf_addr];
  end

  int checks = 0;
  int errors = 0;
  int t = 0;
  int ep = 0;
  int low_cnt = 0;

  logic [7:0] shadow [128];
  bit         sh_init = 1'b0;
  int         due_q [$];
  logic [7:0] val_q [$];
  logic [7:0] exp_char = 8'd0;
  bit         ack_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ep=%0d t=%0d got=%0h expected=%0h", name, ep, t, act, exp);
    end
  endtask

  // Address fetched in a slot, or -1: slots sit two clocks before each visible cell.
  function automatic int slot_addr(input int h, input int v);
    int tv;
    if (h == HT - 2) begin
      tv = (v + 1) % VT;
      return (tv < VA) ? (tv >> CHL) * COLS : -1;
    end
    if ((h + 2) % CW == 0 && h + 2 < HA && v < VA)
      return (v >> CHL) * COLS + (h + 2) / CW;
    return -1;
  endfunction

  task automatic pins();
    case (t)
      0:   check("pin_fs_t0", int'(frame_start), 1);
      8:   check("pin_char_l0_c1", int'(char_out), 1);
      24:  check("pin_char_l0_c3", int'(char_out), 3);
      34:  check("pin_hs_pre", int'(hsync), 1);
      35:  check("pin_hs_first", int'(hsync), 0);
      38:  check("pin_hs_last", int'(hsync), 0);
      39:  check("pin_hs_post", int'(hsync), 1);
      50:  begin check("pin_slot_ack", int'(bus.cpu_wr_ack), 0);
                 check("pin_slot_addr", int'(bus.buf_addr), 1); end
      51:  begin check("pin_wait_ack", int'(bus.cpu_wr_ack), 1);
                 check("pin_wait_we", int'(bus.buf_we), 1);
                 check("pin_wait_addr", int'(bus.buf_addr), 5); end
      100: begin check("pin_drop_ack", int'(bus.cpu_wr_ack), 1);
                 check("pin_drop_we", int'(bus.buf_we), 0); end
      120, 122, 124: check("pin_b2b_ack", int'(bus.cpu_wr_ack), 1);
      121, 123, 125: check("pin_b2b_gap", int'(bus.cpu_wr_ack), 0);
      176: check("pin_char_row1_c0", int'(char_out), 4);
      184: check("pin_char_written", int'(char_out), 8'h41);
      572: check("pin_vs_pre", int'(vsync), 1);
      573: check("pin_vs_first", int'(vsync), 0);
      748: check("pin_fs_frame1", int'(frame_start), 1);
      default: ;
    endcase
  endtask

  // Compare process: model one cycle per falling edge, indexed by cycles since reset release.
  always @(negedge clk) begin
    int h, v, hp, vp, s;
    bit e_ack, e_we, e_hs, e_vs, e_bl;
    if (!sh_init) begin
      for (int i = 0; i < 128; i++) shadow[i] = 8'(i);
      sh_init = 1'b1;
    end
    if (!rst_n) begin
      low_cnt++;
      check("rst_ack", int'(bus.cpu_wr_ack), 0);
      check("rst_we", int'(bus.buf_we), 0);
      check("rst_fs", int'(frame_start), 0);
      if (low_cnt >= 2) begin
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_blank", int'(blank), 1);
        check("rst_valid", int'(char_valid), 0);
        check("rst_char", int'(char_out), 0);
      end
      t = 0;
      due_q.delete();
      val_q.delete();
      exp_char = 8'd0;
      ack_prev = 1'b0;
    end else begin
      if (low_cnt != 0) begin
        ep++;
        low_cnt = 0;
      end
      h = t % HT;
      v = (t / HT) % VT;
      s = slot_addr(h, v);
      e_ack = bus.cpu_wr_req && (s < 0) && !ack_prev;
      e_we  = e_ack && (int'(bus.cpu_wr_addr) < NC);
      if (s >= 0) begin
        due_q.push_back(t + 2);
        val_q.push_back(shadow[s]);
      end
      if (due_q.size() > 0 && due_q[0] == t) begin
        exp_char = val_q.pop_front();
        void'(due_q.pop_front());
      end
      if (t == 0) begin
        e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1;
      end else begin
        hp = (t - 1) % HT;
        vp = ((t - 1) / HT) % VT;
        e_hs = !(hp >= HA + HFP && hp < HA + HFP + HS);
        e_vs = !(vp >= VA + VFP && vp < VA + VFP + VS);
        e_bl = !(hp < HA && vp < VA);
      end
      check("ack", int'(bus.cpu_wr_ack), int'(e_ack));
      check("we", int'(bus.buf_we), int'(e_we));
      check("frame_start", int'(frame_start), int'(h == 0 && v == 0));
      check("hsync", int'(hsync), int'(e_hs));
      check("vsync", int'(vsync), int'(e_vs));
      check("blank", int'(blank), int'(e_bl));
      check("char_valid", int'(char_valid), int'(!e_bl));
      check("char_out", int'(char_out), int'(exp_char));
      if (s >= 0)
        check("fetch_addr", int'(bus.buf_addr), s);
      else if (e_ack)
        check("wr_addr", int'(bus.buf_addr), int'(bus.cpu_wr_addr));
      if (e_we) begin
        check("wr_data", int'(bus.buf_wdata), int'(bus.cpu_wr_data));
        shadow[bus.cpu_wr_addr] = bus.cpu_wr_data;
      end
      ack_prev = e_ack;
      if (ep == 1) pins();
      t++;
    end
  end

  // Stimulus: directed writes in the first frame, then random requests held until acked.
  initial begin
    bit acked;
    bus.cpu_wr_req  = 1'b0;
    bus.cpu_wr_addr = 7'd0;
    bus.cpu_wr_data = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int gc = 0; gc < 6000; gc++) begin
      @(negedge clk);
      acked = bus.cpu_wr_ack;
      @(posedge clk);
      #1;
      if (gc == 2600) rst_n = 1'b0;
      if (gc == 2603) rst_n = 1'b1;
      if (ep == 1 && t >= 120 && t < 126) begin
        bus.cpu_wr_req  = 1'b1;
        bus.cpu_wr_addr = 7'(8 + (t - 120) / 2);
        bus.cpu_wr_data = 8'(t);
      end else if (ep == 1 && t == 126) begin
        bus.cpu_wr_req = 1'b0;
      end else if (acked) begin
        bus.cpu_wr_req = 1'b0;
      end
      if (ep == 1 && t == 50) begin
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 7'd5; bus.cpu_wr_data = 8'h41;
      end
      if (ep == 1 && t == 100) begin
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 7'd100; bus.cpu_wr_data = 8'h77;
      end
      if (gc >= 1600 && !bus.cpu_wr_req && $urandom_range(0, 3) == 0) begin
        bus.cpu_wr_req  = 1'b1;
        bus.cpu_wr_addr = 7'($urandom_range(0, 15));
        bus.cpu_wr_data = 8'($urandom);
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
